// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two core masters, the arbiter and the single-port data RAM.
// The slave modport is the arbiter's view; the master modport is the core/RAM harness side.
interface ram_arbiter_if;
    logic        m0_req_i;
    logic [31:0] m0_addr_i;
    logic        m0_gnt_o;
    logic        m0_rvalid_o;
    logic [31:0] m0_rdata_o;

    logic        m1_req_i;
    logic [31:0] m1_addr_i;
    logic        m1_we_i;
    logic [31:0] m1_wdata_i;
    logic [3:0]  m1_wsel_i;
    logic        m1_gnt_o;
    logic        m1_rvalid_o;
    logic [31:0] m1_rdata_o;

    logic [31:0] ram_addr_o;
    logic        ram_w_en_o;
    logic [31:0] ram_w_data_o;
    logic [3:0]  ram_w_sel_o;
    logic [31:0] ram_r_data_i;

    modport slave (
        input  m0_req_i, m0_addr_i,
        input  m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_wsel_i,
        input  ram_r_data_i,
        output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        output ram_addr_o, ram_w_en_o, ram_w_data_o, ram_w_sel_o
    );

    modport master (
        output m0_req_i, m0_addr_i,
        output m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i, m1_wsel_i,
        output ram_r_data_i,
        input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
        input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
        input  ram_addr_o, ram_w_en_o, ram_w_data_o, ram_w_sel_o
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM: LSU (m1) priority with fetch (m0) starvation guard,
// one-cycle registered response. Define RAM_ARB_PERF_EN to add grant/conflict perf counters.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
`ifdef RAM_ARB_PERF_EN
    ,
    parameter int unsigned PERF_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    ram_arbiter_if.slave      bus
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_m0_o,
    output logic [PERF_W-1:0] perf_m1_o,
    output logic [PERF_W-1:0] perf_conf_o
`endif
);

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    logic [3:0]  starve_q, starve_d;
    logic        rvalid0_q, rvalid0_d;
    logic        rvalid1_q, rvalid1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        gnt0, gnt1;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    always_comb begin
        gnt0 = bus.m0_req_i & (~bus.m1_req_i | (starve_q == StarveMax)) & rst_n;
        gnt1 = bus.m1_req_i & ~gnt0 & rst_n;
    end

    always_comb begin
        bus.m0_gnt_o     = gnt0;
        bus.m1_gnt_o     = gnt1;
        bus.ram_addr_o   = gnt1 ? bus.m1_addr_i : bus.m0_addr_i;
        bus.ram_w_en_o   = gnt1 & bus.m1_we_i;
        bus.ram_w_data_o = gnt1 ? bus.m1_wdata_i : 32'h0;
        bus.ram_w_sel_o  = gnt1 ? bus.m1_wsel_i : 4'h0;
        bus.m0_rvalid_o  = rvalid0_q;
        bus.m0_rdata_o   = rdata0_q;
        bus.m1_rvalid_o  = rvalid1_q;
        bus.m1_rdata_o   = rdata1_q;
    end

    always_comb begin
        starve_d = 4'h0;
        if (bus.m0_req_i && !gnt0) begin
            starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'h1;
        end
        rvalid0_d = gnt0;
        rvalid1_d = gnt1;
        rdata0_d  = gnt0 ? bus.ram_r_data_i : rdata0_q;
        // Write completions report zero; the RAM read data of that cycle is the old word.
        rdata1_d  = rdata1_q;
        if (gnt1) begin
            rdata1_d = bus.m1_we_i ? 32'h0 : bus.ram_r_data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q  <= 4'h0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
        end else begin
            starve_q  <= starve_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_m0_q, perf_m0_d;
    logic [PERF_W-1:0] perf_m1_q, perf_m1_d;
    logic [PERF_W-1:0] perf_conf_q, perf_conf_d;

    always_comb begin
        perf_m0_d   = perf_m0_q + PERF_W'(gnt0);
        perf_m1_d   = perf_m1_q + PERF_W'(gnt1);
        perf_conf_d = perf_conf_q + PERF_W'(bus.m0_req_i & bus.m1_req_i);
        perf_m0_o   = perf_m0_q;
        perf_m1_o   = perf_m1_q;
        perf_conf_o = perf_conf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_m0_q   <= '0;
            perf_m1_q   <= '0;
            perf_conf_q <= '0;
        end else begin
            perf_m0_q   <= perf_m0_d;
            perf_m1_q   <= perf_m1_d;
            perf_conf_q <= perf_conf_d;
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic against a transaction-level model
// with its own copy of the RAM contents.
module tb_ram_arbiter;
    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned PERF_W       = 32;

    logic clk;
    logic rst_n;
    ram_arbiter_if bus ();

`ifdef RAM_ARB_PERF_EN
    logic [PERF_W-1:0] perf_m0, perf_m1, perf_conf;
    ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .perf_m0_o(perf_m0), .perf_m1_o(perf_m1), .perf_conf_o(perf_conf)
    );
`else
    ram_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM macro harness: combinational read, synchronous byte-lane write, preload port.
    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;

    assign bus.ram_r_data_i = mem[bus.ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_idx] <= pre_data;
        end else if (bus.ram_w_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.ram_w_sel_o[b]) mem[bus.ram_addr_o[9:2]][8*b +: 8] <= bus.ram_w_data_o[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [256];
    int          denials;
    logic        pv0, pv1;
    logic [31:0] last0, last1;
    int          cnt_m0, cnt_m1, cnt_conf;
    logic        obs_g0, obs_g1;

    int checks;
    int failures;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        denials = 0;
        pv0 = 1'b0;
        pv1 = 1'b0;
        last0 = 32'h0;
        last1 = 32'h0;
        cnt_m0 = 0;
        cnt_m1 = 0;
        cnt_conf = 0;
    endtask

    // One bus cycle; entered and left at posedge+1.
    task automatic step(input logic r0, input logic [31:0] a0, input logic r1, input logic [31:0] a1,
                        input logic we, input logic [31:0] wd, input logic [3:0] ws);
        logic g0, g1;
        logic [31:0] w;
        bus.m0_req_i   = r0;
        bus.m0_addr_i  = a0;
        bus.m1_req_i   = r1;
        bus.m1_addr_i  = a1;
        bus.m1_we_i    = we;
        bus.m1_wdata_i = wd;
        bus.m1_wsel_i  = ws;
        #3;
        g0 = r0 && (!r1 || denials >= int'(STARVE_LIMIT));
        g1 = r1 && !g0;
        obs_g0 = bus.m0_gnt_o;
        obs_g1 = bus.m1_gnt_o;
        check("m0_gnt", 32'(bus.m0_gnt_o), 32'(g0));
        check("m1_gnt", 32'(bus.m1_gnt_o), 32'(g1));
        check("ram_addr", bus.ram_addr_o, g1 ? a1 : a0);
        check("ram_w_en", 32'(bus.ram_w_en_o), 32'(g1 && we));
        check("ram_w_sel", 32'(bus.ram_w_sel_o), g1 ? 32'(ws) : 32'h0);
        check("ram_w_data", bus.ram_w_data_o, g1 ? wd : 32'h0);
        check("m0_rvalid", 32'(bus.m0_rvalid_o), 32'(pv0));
        check("m0_rdata", bus.m0_rdata_o, last0);
        check("m1_rvalid", 32'(bus.m1_rvalid_o), 32'(pv1));
        check("m1_rdata", bus.m1_rdata_o, last1);
        pv0 = g0;
        pv1 = g1;
        if (g0) last0 = ref_mem[a0[9:2]];
        if (g1) begin
            last1 = we ? 32'h0 : ref_mem[a1[9:2]];
            if (we) begin
                w = ref_mem[a1[9:2]];
                for (int b = 0; b < 4; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
                ref_mem[a1[9:2]] = w;
            end
        end
        denials = (r0 && !g0) ? denials + 1 : 0;
        cnt_m0 += int'(g0);
        cnt_m1 += int'(g1);
        cnt_conf += int'(r0 && r1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        logic [9:0]  pat;
        logic [31:0] ra0, ra1;
`ifdef RAM_ARB_PERF_EN
        int s_m0, s_m1, s_conf;
`endif
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        pre_we = 1'b0;
        pre_idx = 8'h0;
        pre_data = 32'h0;
        bus.m0_req_i = 1'b0;
        bus.m0_addr_i = 32'h0;
        bus.m1_req_i = 1'b0;
        bus.m1_addr_i = 32'h0;
        bus.m1_we_i = 1'b0;
        bus.m1_wdata_i = 32'h0;
        bus.m1_wsel_i = 4'h0;
        model_reset();

        // Preload RAM while in reset
        for (int i = 0; i < 256; i++) begin
            @(posedge clk);
            #1;
            pre_we = 1'b1;
            pre_idx = 8'(i);
            case (i)
                4: pre_data = 32'hDEADBEEF;
                8: pre_data = 32'hAABBCCDD;
                default: pre_data = $urandom;
            endcase
            ref_mem[i] = pre_data;
        end
        @(posedge clk);
        #1;
        pre_we = 1'b0;

        // Reset state with both requests asserted
        bus.m0_req_i = 1'b1;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b1;
        #2;
        check("rst_m0_gnt", 32'(bus.m0_gnt_o), 32'h0);
        check("rst_m1_gnt", 32'(bus.m1_gnt_o), 32'h0);
        check("rst_w_en", 32'(bus.ram_w_en_o), 32'h0);
        check("rst_m0_rvalid", 32'(bus.m0_rvalid_o), 32'h0);
        check("rst_m1_rvalid", 32'(bus.m1_rvalid_o), 32'h0);
        check("rst_m0_rdata", bus.m0_rdata_o, 32'h0);
        check("rst_m1_rdata", bus.m1_rdata_o, 32'h0);
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        bus.m1_we_i = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: fetch read
        step(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        check("t1_gnt", 32'(obs_g0), 32'h1);
        idle();
        check("t1_rdata", bus.m0_rdata_o, 32'hDEADBEEF);

        // 2: masked LSU write then read back
        step(1'b0, 32'h0, 1'b1, 32'h20, 1'b1, 32'h11223344, 4'b0101);
        check("t2_rvalid", 32'(bus.m1_rvalid_o), 32'h1);
        check("t2_rdata_zero", bus.m1_rdata_o, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
        idle();
        check("t2_merged", bus.m1_rdata_o, 32'hAA22CC44);

        // 3: sustained conflict, spec grant pattern for STARVE_LIMIT=4 (1 = m0)
        pat = 10'b1000010000;
`ifdef RAM_ARB_PERF_EN
        s_m0 = int'(perf_m0);
        s_m1 = int'(perf_m1);
        s_conf = int'(perf_conf);
`endif
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h10, 1'b1, 32'h20, 1'b0, 32'h0, 4'h0);
            check($sformatf("t3_m0_gnt_%0d", i), 32'(obs_g0), 32'(pat[i]));
        end
`ifdef RAM_ARB_PERF_EN
        idle();
        check("t6_perf_m0", 32'(int'(perf_m0) - s_m0), 32'd2);
        check("t6_perf_m1", 32'(int'(perf_m1) - s_m1), 32'd8);
        check("t6_perf_conf", 32'(int'(perf_conf) - s_conf), 32'd10);
`endif
        idle();

        // 4: same-address write/read collision
        step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 32'h5, 4'hF);
        check("t4_m1_first", 32'(obs_g1), 32'h1);
        step(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        idle();
        check("t4_new_data", bus.m0_rdata_o, 32'h5);

        // 5: asynchronous reset with an m0 response pending
        bus.m0_req_i = 1'b1;
        bus.m0_addr_i = 32'h10;
        #3;
        check("t5_gnt", 32'(bus.m0_gnt_o), 32'h1);
        #2;
        rst_n = 1'b0;
        bus.m1_req_i = 1'b1;
        bus.m1_we_i = 1'b1;
        #1;
        check("t5_m0_gnt", 32'(bus.m0_gnt_o), 32'h0);
        check("t5_m1_gnt", 32'(bus.m1_gnt_o), 32'h0);
        check("t5_w_en", 32'(bus.ram_w_en_o), 32'h0);
        check("t5_m0_rdata", bus.m0_rdata_o, 32'h0);
        @(posedge clk);
        #1;
        check("t5_m0_rvalid_in_rst", 32'(bus.m0_rvalid_o), 32'h0);
        check("t5_m1_rvalid_in_rst", 32'(bus.m1_rvalid_o), 32'h0);
        bus.m0_req_i = 1'b0;
        bus.m1_req_i = 1'b0;
        bus.m1_we_i = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t5_no_rvalid", 32'(bus.m0_rvalid_o), 32'h0);
        model_reset();

        // Random traffic over a small address window to provoke collisions
        for (int i = 0; i < 400; i++) begin
            ra0 = 32'($urandom_range(0, 15)) << 2;
            ra1 = 32'($urandom_range(0, 15)) << 2;
            step(1'($urandom_range(0, 3) != 0), ra0, 1'($urandom_range(0, 2) != 0), ra1,
                 1'($urandom), $urandom, 4'($urandom));
        end
        idle();
`ifdef RAM_ARB_PERF_EN
        check("perf_m0_total", perf_m0, 32'(cnt_m0));
        check("perf_m1_total", perf_m1, 32'(cnt_m1));
        check("perf_conf_total", perf_conf, 32'(cnt_conf));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
